// File: rtl/mod_n_pkg.sv
// rtl/mod_n_pkg.sv - shared constants, types and helpers for the modulo-N up/down counter
package mod_n_pkg;

  localparam int DEF_MOD    = 12;
  localparam int WRAP_CNT_W = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Count width for a modulus; never below one bit so a degenerate modulus still elaborates.
  function automatic int mod_width(int m);
    int w;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// rtl/sat_event_counter.sv - saturating event counter, sticks at all-ones
module sat_event_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count events until all-ones, then hold; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - modulo-N up/down counter with load, cascade tc, wrap and load_err pulses; optional wrap_cnt under MOD_N_UPDOWN_COUNTER_WRAP_CNT_EN
module mod_n_updown_counter
  import mod_n_pkg::*;
#(
  parameter int MOD   = DEF_MOD,
  parameter int WIDTH = mod_width(MOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] c_out,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
`ifdef MOD_N_UPDOWN_COUNTER_WRAP_CNT_EN
  ,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

  generate
    if ((MOD < 2) || (MOD > 65536)) begin : g_bad_mod
      $error("mod_n_updown_counter: MOD must be in 2..65536");
    end
    if ((64'd1 << WIDTH) < 64'(MOD)) begin : g_bad_width
      $error("mod_n_updown_counter: WIDTH too small for MOD");
    end
  endgenerate

  // One extra bit so MOD itself is representable when MOD == 2**WIDTH.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  dir_e             dir;
  logic [WIDTH:0]   cnt_ext;
  logic             at_max;
  logic             at_zero;
  logic             out_range;
  logic             d_ok;
  logic [WIDTH-1:0] c_nxt;
  logic             wrap_nxt;
  logic             err_nxt;

  assign dir       = dir_e'(up_dn);
  assign cnt_ext   = {1'b0, c_out};
  assign at_max    = (cnt_ext == MAX_EXT);
  assign at_zero   = (c_out == '0);
  assign out_range = (cnt_ext >= MOD_EXT);
  assign d_ok      = ({1'b0, d_in} < MOD_EXT);

  // Terminal count is live in the cycle before the wrapping edge so a cascaded stage can use it as en.
  assign tc = en & ~load & ~rst & ((dir == DIR_UP) ? at_max : at_zero);

  // Next count and pulse values: load beats count, count beats hold.
  always_comb begin
    c_nxt    = c_out;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      if (d_ok) begin
        c_nxt = d_in;
      end else begin
        c_nxt   = '0;
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (out_range) begin
        // Corrupted state recovers to zero silently rather than faking a wrap.
        c_nxt = '0;
      end else if (dir == DIR_UP) begin
        if (at_max) begin
          c_nxt    = '0;
          wrap_nxt = 1'b1;
        end else begin
          c_nxt = WIDTH'(cnt_ext + ONE_EXT);
        end
      end else begin
        if (at_zero) begin
          c_nxt    = MAX_EXT[WIDTH-1:0];
          wrap_nxt = 1'b1;
        end else begin
          c_nxt = WIDTH'(cnt_ext - ONE_EXT);
        end
      end
    end
  end

  // Count and pulse registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_out    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      c_out    <= c_nxt;
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

`ifdef MOD_N_UPDOWN_COUNTER_WRAP_CNT_EN
  // Bumped on the same edge that raises wrap, so count and pulse appear together.
  sat_event_counter #(
    .WIDTH(WRAP_CNT_W)
  ) u_wrap_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (wrap_nxt),
    .count(wrap_cnt)
  );
`endif

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb/tb_mod_n_updown_counter.sv - directed self-checking bench for mod_n_updown_counter
module tb_mod_n_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic       up_dn;
  logic [3:0] d_in;
  logic [3:0] c_out;
  logic       tc;
  logic       wrap;
  logic       load_err;

  logic       c_rst;
  logic       c_en;
  logic [3:0] s1_c;
  logic [3:0] s2_c;
  logic       s1_tc;
  logic       s2_tc;
  logic       s1_wrap;
  logic       s2_wrap;
  logic       s1_err;
  logic       s2_err;
`ifdef MOD_N_UPDOWN_COUNTER_WRAP_CNT_EN
  logic [15:0] dut_wcnt;
  logic [15:0] s1_wcnt;
  logic [15:0] s2_wcnt;
`endif

  int checks;
  int failures;
  int exp_c;
  int prev_c;

  mod_n_updown_counter #(.MOD(12)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .up_dn(up_dn), .d_in(d_in),
    .c_out(c_out), .tc(tc), .wrap(wrap), .load_err(load_err)
`ifdef MOD_N_UPDOWN_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(dut_wcnt)
`endif
  );

  mod_n_updown_counter #(.MOD(16)) s1 (
    .clk(clk), .rst(c_rst), .en(c_en), .load(1'b0), .up_dn(1'b1), .d_in(4'd0),
    .c_out(s1_c), .tc(s1_tc), .wrap(s1_wrap), .load_err(s1_err)
`ifdef MOD_N_UPDOWN_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(s1_wcnt)
`endif
  );

  mod_n_updown_counter #(.MOD(16)) s2 (
    .clk(clk), .rst(c_rst), .en(s1_tc), .load(1'b0), .up_dn(1'b1), .d_in(4'd0),
    .c_out(s2_c), .tc(s2_tc), .wrap(s2_wrap), .load_err(s2_err)
`ifdef MOD_N_UPDOWN_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(s2_wcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; up_dn = 1'b1; d_in = 4'd0;
    c_rst = 1'b1; c_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset c_out", 32'(c_out), 32'd0);
    check("reset wrap", 32'(wrap), 32'd0);
    check("reset load_err", 32'(load_err), 32'd0);

    // Up count through one full wrap.
    en = 1'b1; up_dn = 1'b1;
    exp_c = 0;
    for (int i = 1; i <= 13; i++) begin
      #1;
      check("up tc", 32'(tc), 32'(exp_c == 11));
      prev_c = exp_c;
      exp_c = (exp_c == 11) ? 0 : exp_c + 1;
      tick();
      check("up c_out", 32'(c_out), 32'(exp_c));
      check("up wrap", 32'(wrap), 32'(prev_c == 11));
    end

    // Down count from reset: first edge wraps to 11.
    rst = 1'b1;
    tick();
    rst = 1'b0; up_dn = 1'b0;
    exp_c = 0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check("down tc", 32'(tc), 32'(exp_c == 0));
      prev_c = exp_c;
      exp_c = (exp_c == 0) ? 11 : exp_c - 1;
      tick();
      check("down c_out", 32'(c_out), 32'(exp_c));
      check("down wrap", 32'(wrap), 32'(prev_c == 0));
    end

    // Hold when disabled.
    en = 1'b0;
    tick();
    check("hold c_out", 32'(c_out), 32'd7);

    // Loads in and out of range.
    load = 1'b1; d_in = 4'd7;
    tick();
    check("load7 c_out", 32'(c_out), 32'd7);
    check("load7 err", 32'(load_err), 32'd0);
    d_in = 4'd12;
    tick();
    check("load12 c_out", 32'(c_out), 32'd0);
    check("load12 err", 32'(load_err), 32'd1);
    load = 1'b0;
    tick();
    check("err pulse drop", 32'(load_err), 32'd0);
    load = 1'b1; d_in = 4'd15;
    tick();
    check("load15 c_out", 32'(c_out), 32'd0);
    check("load15 err", 32'(load_err), 32'd1);
    load = 1'b0;
    tick();
    check("err pulse drop2", 32'(load_err), 32'd0);

    // Load at terminal state with en: load wins, no wrap, no tc.
    load = 1'b1; d_in = 4'd11;
    tick();
    en = 1'b1; up_dn = 1'b1; d_in = 4'd3;
    #1;
    check("load+term tc", 32'(tc), 32'd0);
    tick();
    check("load+term c_out", 32'(c_out), 32'd3);
    check("load+term wrap", 32'(wrap), 32'd0);

    // Reset beats load and en.
    en = 1'b0; d_in = 4'd5;
    tick();
    check("load5 c_out", 32'(c_out), 32'd5);
    rst = 1'b1; en = 1'b1; load = 1'b1; d_in = 4'd3;
    #1;
    check("rst tc", 32'(tc), 32'd0);
    tick();
    check("rst c_out", 32'(c_out), 32'd0);
    check("rst wrap", 32'(wrap), 32'd0);
    check("rst err", 32'(load_err), 32'd0);
    rst = 1'b0; load = 1'b0;
    tick();
    check("resume1", 32'(c_out), 32'd1);
    tick();
    check("resume2", 32'(c_out), 32'd2);
    up_dn = 1'b0;
    tick();
    check("dir change", 32'(c_out), 32'd1);
`ifdef MOD_N_UPDOWN_COUNTER_WRAP_CNT_EN
    check("dut wrap_cnt after rst", 32'(dut_wcnt), 32'd0);
`endif

    // Two-stage MOD-16 cascade.
    en = 1'b0;
    c_rst = 1'b0; c_en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 16) begin
        check("casc16 s1", 32'(s1_c), 32'd0);
        check("casc16 s2", 32'(s2_c), 32'd1);
      end
    end
    check("casc256 s1", 32'(s1_c), 32'd0);
    check("casc256 s2", 32'(s2_c), 32'd0);
    check("casc256 s2 wrap", 32'(s2_wrap), 32'd1);
    check("casc256 s1 wrap", 32'(s1_wrap), 32'd1);
`ifdef MOD_N_UPDOWN_COUNTER_WRAP_CNT_EN
    check("s1 wrap_cnt", 32'(s1_wcnt), 32'd16);
    check("s2 wrap_cnt", 32'(s2_wcnt), 32'd1);
`endif
    c_en = 1'b0;
    tick();
    check("casc hold s1", 32'(s1_c), 32'd0);
    check("casc wrap drop", 32'(s1_wrap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
